dcache_mem_arbiter: RTL
=======================

# dcache_mem_arbiter

Shares `NUM_CHANNELS` memory-controller channels among the `NUM_CONSUMERS` per-consumer miss/writeback ports of the data cache. It sits between the dcache controller interface and the global memory controller. Each channel runs a small request/relay state machine. Idle channels are assigned to pending cache ports in round-robin order, with writebacks (evictions) ahead of fills on the same port.

## Interface
- `ADDR_BITS`, 8, address width
- `DATA_BITS`, 8, data width
- `NUM_CONSUMERS`, 8, cache-side ports (one per dcache consumer lane)
- `NUM_CHANNELS`, 4, memory-side channels; 1 ≤ `NUM_CHANNELS` ≤ `NUM_CONSUMERS`

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cache_read_valid`  in  NUM_CONSUMERS  fill request per port
- `cache_read_address`  in  NUM_CONSUMERS×ADDR_BITS  fill address
- `cache_read_ready`  out  NUM_CONSUMERS  fill data valid / request done
- `cache_read_data`  out  NUM_CONSUMERS×DATA_BITS  fill data
- `cache_write_valid`  in  NUM_CONSUMERS  writeback request per port
- `cache_write_address`  in  NUM_CONSUMERS×ADDR_BITS  writeback address
- `cache_write_data`  in  NUM_CONSUMERS×DATA_BITS  writeback data
- `cache_write_ready`  out  NUM_CONSUMERS  writeback accepted
- `mem_read_valid`  out  NUM_CHANNELS; `mem_read_address`  out  NUM_CHANNELS×ADDR_BITS
- `mem_read_ready`  in  NUM_CHANNELS; `mem_read_data`  in  NUM_CHANNELS×DATA_BITS
- `mem_write_valid`  out  NUM_CHANNELS; `mem_write_address`  out  NUM_CHANNELS×ADDR_BITS; `mem_write_data`  out  NUM_CHANNELS×DATA_BITS
- `mem_write_ready`  in  NUM_CHANNELS

## Operation
- Per-channel state: IDLE, READ_WAITING, WRITE_WAITING, RELAYING. Each channel also holds `owner`, a consumer index.
- Per-port flag `busy[c]`: set while a channel owns port c.
- A port is pending when it is not busy and `cache_write_valid` or `cache_read_valid` is high. A pending write is served before a pending read on the same port.
- Grant (IDLE):
  - Channels are scanned in ascending index.
  - Each IDLE channel takes the first pending, not-yet-granted-this-cycle port, searching from `rr_ptr` upward with wrap at `NUM_CONSUMERS`.
  - A port is never granted to two channels in one cycle.
  - A write grant drives `mem_write_valid`, address and data, then goes to WRITE_WAITING. A read grant drives `mem_read_valid` and address, then goes to READ_WAITING.
  - Memory outputs are registered and stay stable until the matching ready.
- `rr_ptr` (clog2 width, reset 0): after any cycle with ≥1 grant, it becomes (last granted port + 1) mod `NUM_CONSUMERS`. With no grants it holds.
- READ_WAITING, on `mem_read_ready`:
  - deassert `mem_read_valid`
  - `cache_read_data[owner]` ← `mem_read_data`
  - `cache_read_ready[owner]` ← 1
  - go to RELAYING
- WRITE_WAITING, on `mem_write_ready`: deassert `mem_write_valid`, set `cache_write_ready[owner]` ← 1, go to RELAYING.
- RELAYING: hold ready until the served valid (read or write, whichever was granted) is low. Then clear ready and `busy[owner]`, and go to IDLE.
- Consumer dropping valid during WAITING: the memory transaction still completes. Ready then pulses for exactly one cycle.
- `cache_read_data` holds its last value until overwritten.

## Timing
- Reset (asynchronous, active low): every output 0, all channels IDLE, `busy` = 0, `rr_ptr` = 0. Any in-flight memory transaction is abandoned; no ready is returned for it.
- Grant latency: valid sampled at edge N → memory valid high after edge N.
- Return latency: memory ready sampled at edge M → cache ready/data after edge M. Memory valid is low after the same edge.
- Release: consumer valid low sampled at edge R → ready low and channel IDLE after edge R. The earliest re-grant of that channel is at edge R+1.
- Both valids high on one port: the write is served first; the read is granted no earlier than one cycle after the write's release.
- More pending ports than channels: excess ports wait. Round-robin guarantees that every pending port is granted within `NUM_CONSUMERS` grant cycles.
- Memory read and write valid are never both high on one channel.

## Test plan
- Single fill:
  - stimulus: port 2 read 0x3C; channel 0 memory returns 0xA5 two cycles after its valid
  - required: `mem_read_address[0]` = 0x3C, `cache_read_data[2]` = 0xA5, `cache_read_ready[2]` high until valid drops, then low one edge later
- Saturation:
  - stimulus: `NUM_CHANNELS` = 4, ports 0–7 read simultaneously
  - required: ports 0–3 go to channels 0–3, `rr_ptr` = 4; after release, ports 4–7 are granted before any re-request from 0–3
- Write priority:
  - stimulus: port 5 write 0x10/0x77 and read 0x20 both valid
  - required: memory sees the write (0x10, 0x77) first, then the read 0x20 after `cache_write_valid[5]` drops
- Early drop:
  - stimulus: port 1 drops read valid during READ_WAITING
  - required: `cache_read_ready[1]` is a one-cycle pulse, then the channel returns to IDLE
- Reset mid-operation:
  - stimulus: assert `reset` low while 3 channels are WAITING
  - required: all memory and cache outputs are 0 immediately, without a clock edge; after release, the first grant starts at port 0
- Back-to-back:
  - stimulus: port 0 re-asserts read on the cycle after release
  - required: grant on the next edge, with no duplicate memory request

Source files
------------

// File: rtl/dcache_mem_arbiter.sv
// Shares NUM_CHANNELS memory-controller channels among the dcache miss/writeback ports.
// Each channel runs a request/relay FSM. Idle channels take pending ports in round-robin order, writes before reads.
module dcache_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           cache_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] cache_read_address,
    output logic [NUM_CONSUMERS-1:0]           cache_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] cache_read_data,
    input  logic [NUM_CONSUMERS-1:0]           cache_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] cache_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] cache_write_data,
    output logic [NUM_CONSUMERS-1:0]           cache_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);
    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        RELAYING
    } ch_state_e;

    ch_state_e                          state_q [NUM_CHANNELS];
    ch_state_e                          state_d [NUM_CHANNELS];
    logic [PTR_W-1:0]                   owner_q [NUM_CHANNELS];
    logic [PTR_W-1:0]                   owner_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]            is_write_q, is_write_d;
    logic [NUM_CONSUMERS-1:0]           busy_q, busy_d;
    logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;

    logic [NUM_CONSUMERS-1:0]           cache_read_ready_q, cache_read_ready_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] cache_read_data_q, cache_read_data_d;
    logic [NUM_CONSUMERS-1:0]           cache_write_ready_q, cache_write_ready_d;
    logic [NUM_CHANNELS-1:0]            mem_read_valid_q, mem_read_valid_d;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address_q, mem_read_address_d;
    logic [NUM_CHANNELS-1:0]            mem_write_valid_q, mem_write_valid_d;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address_q, mem_write_address_d;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data_q, mem_write_data_d;

    logic [NUM_CONSUMERS-1:0]           pending;
    logic [NUM_CONSUMERS-1:0]           granted;
    logic                               any_grant;
    logic                               found;
    logic [PTR_W-1:0]                   sel;
    logic [PTR_W-1:0]                   cand;
    logic [PTR_W-1:0]                   last_port;
    int unsigned                        idx;

    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        is_write_d          = is_write_q;
        busy_d              = busy_q;
        rr_ptr_d            = rr_ptr_q;
        cache_read_ready_d  = cache_read_ready_q;
        cache_read_data_d   = cache_read_data_q;
        cache_write_ready_d = cache_write_ready_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;

        pending   = ~busy_q & (cache_read_valid | cache_write_valid);
        granted   = '0;
        any_grant = 1'b0;
        found     = 1'b0;
        sel       = '0;
        cand      = '0;
        last_port = '0;
        idx       = 0;

        // Channels are visited in ascending order so lower channels see the round-robin head first.
        for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
                IDLE: begin
                    found = 1'b0;
                    sel   = '0;
                    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                        idx = 32'(rr_ptr_q) + k;
                        if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
                        cand = PTR_W'(idx);
                        if (!found && pending[cand] && !granted[cand]) begin
                            found = 1'b1;
                            sel   = cand;
                        end
                    end
                    if (found) begin
                        granted[sel] = 1'b1;
                        busy_d[sel]  = 1'b1;
                        owner_d[ch]  = sel;
                        any_grant    = 1'b1;
                        last_port    = sel;
                        if (cache_write_valid[sel]) begin
                            is_write_d[ch]        = 1'b1;
                            mem_write_valid_d[ch] = 1'b1;
                            mem_write_address_d[ch*ADDR_BITS +: ADDR_BITS] =
                                cache_write_address[sel*ADDR_BITS +: ADDR_BITS];
                            mem_write_data_d[ch*DATA_BITS +: DATA_BITS] =
                                cache_write_data[sel*DATA_BITS +: DATA_BITS];
                            state_d[ch] = WRITE_WAITING;
                        end else begin
                            is_write_d[ch]       = 1'b0;
                            mem_read_valid_d[ch] = 1'b1;
                            mem_read_address_d[ch*ADDR_BITS +: ADDR_BITS] =
                                cache_read_address[sel*ADDR_BITS +: ADDR_BITS];
                            state_d[ch] = READ_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready[ch]) begin
                        mem_read_valid_d[ch] = 1'b0;
                        cache_read_data_d[owner_q[ch]*DATA_BITS +: DATA_BITS] =
                            mem_read_data[ch*DATA_BITS +: DATA_BITS];
                        cache_read_ready_d[owner_q[ch]] = 1'b1;
                        state_d[ch] = RELAYING;
                    end
                end
                WRITE_WAITING: begin
                    if (mem_write_ready[ch]) begin
                        mem_write_valid_d[ch]            = 1'b0;
                        cache_write_ready_d[owner_q[ch]] = 1'b1;
                        state_d[ch]                      = RELAYING;
                    end
                end
                RELAYING: begin
                    if (is_write_q[ch]) begin
                        if (!cache_write_valid[owner_q[ch]]) begin
                            cache_write_ready_d[owner_q[ch]] = 1'b0;
                            busy_d[owner_q[ch]]              = 1'b0;
                            state_d[ch]                      = IDLE;
                        end
                    end else if (!cache_read_valid[owner_q[ch]]) begin
                        cache_read_ready_d[owner_q[ch]] = 1'b0;
                        busy_d[owner_q[ch]]             = 1'b0;
                        state_d[ch]                     = IDLE;
                    end
                end
                default: state_d[ch] = IDLE;
            endcase
        end

        if (any_grant) begin
            rr_ptr_d = (last_port == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : last_port + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= '{default: IDLE};
            owner_q             <= '{default: '0};
            is_write_q          <= '0;
            busy_q              <= '0;
            rr_ptr_q            <= '0;
            cache_read_ready_q  <= '0;
            cache_read_data_q   <= '0;
            cache_write_ready_q <= '0;
            mem_read_valid_q    <= '0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= '0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
        end else begin
            state_q             <= state_d;
            owner_q             <= owner_d;
            is_write_q          <= is_write_d;
            busy_q              <= busy_d;
            rr_ptr_q            <= rr_ptr_d;
            cache_read_ready_q  <= cache_read_ready_d;
            cache_read_data_q   <= cache_read_data_d;
            cache_write_ready_q <= cache_write_ready_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
        end
    end

    assign cache_read_ready  = cache_read_ready_q;
    assign cache_read_data   = cache_read_data_q;
    assign cache_write_ready = cache_write_ready_q;
    assign mem_read_valid    = mem_read_valid_q;
    assign mem_read_address  = mem_read_address_q;
    assign mem_write_valid   = mem_write_valid_q;
    assign mem_write_address = mem_write_address_q;
    assign mem_write_data    = mem_write_data_q;

endmodule
